register_tree_kv: RTL and testbench



---
 rtl/register_tree_kv.sv | 243 ++++++++++++++++++++++++
 tb/tb_register_tree_kv.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_tree_kv.sv
// register_tree_kv
// ----------------
// Register-based binary-heap priority queue of {key, val} entries. The root
// (slot 0) always holds the best entry: the largest key when MAX_MODE=1 and
// the smallest key when MAX_MODE=0. The payload travels with its key and is
// never compared. Keys are compared strictly, so entries with equal keys are
// never swapped.
//
// A command is accepted only while o_ready=1, which means the FSM is in IDLE.
// After an insert, the new entry sifts up from the tail. After a remove or a
// replace, the entry written into the root sifts down. Each step takes one
// cycle.
//
// Ports
//   i_CLK    clock; all state changes on the rising edge
//   i_RST    synchronous active-high reset; clears the count and every slot
//   i_wrt    insert request (with i_read: replace root)
//   i_read   remove-root request
//   i_key    key to insert or replace
//   i_val    payload to insert or replace
//   o_ready  high in IDLE; commands are sampled only then
//   o_full   count == QUEUE_SIZE
//   o_empty  count == 0
//   o_count  current occupancy
//   o_key    root key, 0 when empty
//   o_val    root payload, 0 when empty
//   o_drop   one-cycle pulse after an accepted command that was illegal
module register_tree_kv #(
  parameter int QUEUE_SIZE = 7,
  parameter int KEY_WIDTH  = 16,
  parameter int VAL_WIDTH  = 8,
  parameter int MAX_MODE   = 1
) (
  input  logic                              i_CLK,
  input  logic                              i_RST,
  input  logic                              i_wrt,
  input  logic                              i_read,
  input  logic [KEY_WIDTH-1:0]              i_key,
  input  logic [VAL_WIDTH-1:0]              i_val,
  output logic                              o_ready,
  output logic                              o_full,
  output logic                              o_empty,
  output logic [$clog2(QUEUE_SIZE+1)-1:0]   o_count,
  output logic [KEY_WIDTH-1:0]              o_key,
  output logic [VAL_WIDTH-1:0]              o_val,
  output logic                              o_drop
);

  localparam int CNT_W = $clog2(QUEUE_SIZE + 1);
  localparam int IDX_W = $clog2(QUEUE_SIZE);
  // Child indices (2i+1, 2i+2) can run past the array. They get two extra
  // bits so the range test against count never wraps.
  localparam int CH_W  = IDX_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SIFT_UP,
    ST_SIFT_DOWN
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       count_reg, count_next;
  logic [IDX_W-1:0]       cursor_reg, cursor_next;
  logic                   drop_reg, drop_next;
  logic [KEY_WIDTH-1:0]   key_reg [QUEUE_SIZE];
  logic [VAL_WIDTH-1:0]   val_reg [QUEUE_SIZE];

  // Two write ports are needed, because a swap moves two slots in one cycle.
  logic                   wa_en, wb_en;
  logic [IDX_W-1:0]       wa_idx, wb_idx;
  logic [KEY_WIDTH-1:0]   wa_key, wb_key;
  logic [VAL_WIDTH-1:0]   wa_val, wb_val;

  // "a beats b" under the selected ordering (strict).
  function automatic logic beats(input logic [KEY_WIDTH-1:0] a,
                                 input logic [KEY_WIDTH-1:0] b);
    if (MAX_MODE != 0) return a > b;
    else               return a < b;
  endfunction

  logic                   is_full, is_empty;
  logic [IDX_W-1:0]       tail_idx, last_idx, parent_idx;
  logic [CH_W-1:0]        cnt_w, cur_w, left_w, right_w, child_w, grand_w;
  logic                   left_valid, right_valid, pick_right;
  logic [IDX_W-1:0]       left_idx, right_idx, child_idx;

  always_comb begin
    is_full     = (count_reg == CNT_W'(QUEUE_SIZE));
    is_empty    = (count_reg == '0);
    tail_idx    = IDX_W'(count_reg);
    last_idx    = IDX_W'(count_reg - CNT_W'(1));
    parent_idx  = (cursor_reg - IDX_W'(1)) >> 1;

    cnt_w       = CH_W'(count_reg);
    cur_w       = CH_W'(cursor_reg);
    left_w      = (cur_w << 1) | CH_W'(1);
    right_w     = left_w + CH_W'(1);
    left_valid  = (left_w  < cnt_w);
    right_valid = (right_w < cnt_w);
    // Indices are clamped to 0 when a child does not exist, so the array is
    // never read out of range.
    left_idx    = left_valid  ? IDX_W'(left_w)  : '0;
    right_idx   = right_valid ? IDX_W'(right_w) : '0;
    // The left child wins ties, and is also chosen when it is the only child.
    pick_right  = right_valid && beats(key_reg[right_idx], key_reg[left_idx]);
    child_idx   = pick_right ? right_idx : left_idx;
    child_w     = CH_W'(child_idx);
    grand_w     = (child_w << 1) | CH_W'(1);
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    cursor_next = cursor_reg;
    drop_next   = 1'b0;
    wa_en       = 1'b0;
    wa_idx      = '0;
    wa_key      = '0;
    wa_val      = '0;
    wb_en       = 1'b0;
    wb_idx      = '0;
    wb_key      = '0;
    wb_val      = '0;

    unique case (state_reg)
      ST_IDLE: begin
        // A replace on an empty queue behaves as an insert.
        if (i_wrt && (!i_read || is_empty)) begin
          if (is_full) begin
            drop_next = 1'b1;
          end else begin
            wa_en       = 1'b1;
            wa_idx      = tail_idx;
            wa_key      = i_key;
            wa_val      = i_val;
            count_next  = count_reg + CNT_W'(1);
            cursor_next = tail_idx;
            if (!is_empty) state_next = ST_SIFT_UP;
          end
        end else if (i_read && !i_wrt) begin
          if (is_empty) begin
            drop_next = 1'b1;
          end else begin
            wa_en       = 1'b1;
            wa_idx      = '0;
            wa_key      = key_reg[last_idx];
            wa_val      = val_reg[last_idx];
            count_next  = count_reg - CNT_W'(1);
            cursor_next = '0;
            // The remaining count is count-1, so a sift is needed only if
            // more than one entry is left.
            if (count_reg > CNT_W'(2)) state_next = ST_SIFT_DOWN;
          end
        end else if (i_wrt && i_read) begin
          wa_en       = 1'b1;
          wa_idx      = '0;
          wa_key      = i_key;
          wa_val      = i_val;
          cursor_next = '0;
          if (count_reg > CNT_W'(1)) state_next = ST_SIFT_DOWN;
        end
      end

      ST_SIFT_UP: begin
        // The cursor is always non-zero in this state.
        if (beats(key_reg[cursor_reg], key_reg[parent_idx])) begin
          wa_en       = 1'b1;
          wa_idx      = cursor_reg;
          wa_key      = key_reg[parent_idx];
          wa_val      = val_reg[parent_idx];
          wb_en       = 1'b1;
          wb_idx      = parent_idx;
          wb_key      = key_reg[cursor_reg];
          wb_val      = val_reg[cursor_reg];
          cursor_next = parent_idx;
          if (parent_idx == '0) state_next = ST_IDLE;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_SIFT_DOWN: begin
        if (left_valid && beats(key_reg[child_idx], key_reg[cursor_reg])) begin
          wa_en       = 1'b1;
          wa_idx      = cursor_reg;
          wa_key      = key_reg[child_idx];
          wa_val      = val_reg[child_idx];
          wb_en       = 1'b1;
          wb_idx      = child_idx;
          wb_key      = key_reg[cursor_reg];
          wb_val      = val_reg[cursor_reg];
          cursor_next = child_idx;
          // Stop early when the moved entry has reached a leaf.
          if (!(grand_w < cnt_w)) state_next = ST_IDLE;
        end else begin
          state_next = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      cursor_reg <= '0;
      drop_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      cursor_reg <= cursor_next;
      drop_reg   <= drop_next;
    end
  end

  always_ff @(posedge i_CLK) begin
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      if (i_RST) begin
        key_reg[i] <= '0;
        val_reg[i] <= '0;
      end else if (wa_en && (wa_idx == IDX_W'(i))) begin
        key_reg[i] <= wa_key;
        val_reg[i] <= wa_val;
      end else if (wb_en && (wb_idx == IDX_W'(i))) begin
        key_reg[i] <= wb_key;
        val_reg[i] <= wb_val;
      end
    end
  end

  assign o_ready = (state_reg == ST_IDLE);
  assign o_full  = is_full;
  assign o_empty = is_empty;
  assign o_count = count_reg;
  // Slot 0 may still hold stale data after the last entry leaves, so the
  // outputs are forced to zero when the queue is empty.
  assign o_key   = is_empty ? '0 : key_reg[0];
  assign o_val   = is_empty ? '0 : val_reg[0];
  assign o_drop  = drop_reg;

endmodule

// File: tb/tb_register_tree_kv.sv
// Scoreboard bench for register_tree_kv. There are two instances: a
// max-ordered one and a min-ordered one. They share a reset, and sel routes
// the commands and the observed outputs to one of them. The stimulus pushes
// the expected post-command state. The monitor pops that entry when the
// selected DUT is ready again after an accept edge.
module tb_register_tree_kv;
  localparam int QS = 7;
  localparam int KW = 16;
  localparam int VW = 8;
  localparam int CW = 3;

  logic          clk;
  logic          rst, wrt, rd, sel;
  logic [KW-1:0] key;
  logic [VW-1:0] val;

  logic          rdy0, full0, empty0, drop0, rdy1, full1, empty1, drop1;
  logic [CW-1:0] cnt0, cnt1;
  logic [KW-1:0] key0, key1;
  logic [VW-1:0] val0, val1;

  register_tree_kv #(.QUEUE_SIZE(QS), .KEY_WIDTH(KW), .VAL_WIDTH(VW), .MAX_MODE(1)) dut_max (
    .i_CLK(clk), .i_RST(rst), .i_wrt(wrt && !sel), .i_read(rd && !sel),
    .i_key(key), .i_val(val), .o_ready(rdy0), .o_full(full0), .o_empty(empty0),
    .o_count(cnt0), .o_key(key0), .o_val(val0), .o_drop(drop0)
  );

  register_tree_kv #(.QUEUE_SIZE(QS), .KEY_WIDTH(KW), .VAL_WIDTH(VW), .MAX_MODE(0)) dut_min (
    .i_CLK(clk), .i_RST(rst), .i_wrt(wrt && sel), .i_read(rd && sel),
    .i_key(key), .i_val(val), .o_ready(rdy1), .o_full(full1), .o_empty(empty1),
    .o_count(cnt1), .o_key(key1), .o_val(val1), .o_drop(drop1)
  );

  logic          m_ready, m_full, m_empty, m_drop;
  logic [CW-1:0] m_cnt;
  logic [KW-1:0] m_key;
  logic [VW-1:0] m_val;
  assign m_ready = sel ? rdy1   : rdy0;
  assign m_full  = sel ? full1  : full0;
  assign m_empty = sel ? empty1 : empty0;
  assign m_drop  = sel ? drop1  : drop0;
  assign m_cnt   = sel ? cnt1   : cnt0;
  assign m_key   = sel ? key1   : key0;
  assign m_val   = sel ? val1   : val0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string name;
    int    key;
    int    val;
    int    cnt;
    int    drop;
  } exp_t;

  exp_t sb_q[$];
  int checks   = 0;
  int errors   = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int busy     = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, req);
    end
  endtask

  // Accept detector: it samples pre-edge values, as a flop would. A reset
  // edge counts as one transaction whose expectation is the cleared state.
  initial forever begin
    @(posedge clk);
    if (rst) acc_cnt = done_cnt + 1;
    else if (m_ready && (wrt || rd)) acc_cnt = acc_cnt + 1;
  end

  // Monitor: on the falling edge, compare the oldest expectation once the
  // DUT is ready again.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      busy = 0;
    end else if (acc_cnt != done_cnt) begin
      if (!m_ready) begin
        busy++;
      end else begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, ".key"},   int'(m_key),   e.key);
          chk({e.name, ".val"},   int'(m_val),   e.val);
          chk({e.name, ".count"}, int'(m_cnt),   e.cnt);
          chk({e.name, ".empty"}, int'(m_empty), (e.cnt == 0) ? 1 : 0);
          chk({e.name, ".full"},  int'(m_full),  (e.cnt == QS) ? 1 : 0);
          chk({e.name, ".drop"},  int'(m_drop),  e.drop);
          chk({e.name, ".busy_le2"}, (busy <= 2) ? 1 : 0, 1);
          $display("txn %s key=%0d val=%0d cnt=%0d drop=%0d busy=%0d",
                   e.name, m_key, m_val, m_cnt, m_drop, busy);
        end
        done_cnt++;
        busy = 0;
      end
    end
  end

  // Wait for ready, hold the command for one accept edge, and queue its
  // expected result. With hold=1 the request stays up for one more edge,
  // which must land while the DUT is busy and so be ignored.
  task automatic issue(input string nm, input bit w, input bit r, input int k, input int v,
                       input int ek, input int ev, input int ec, input int ed, input bit hold);
    exp_t e;
    int t;
    t = 0;
    while (!m_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!m_ready) begin
      chk({nm, ".ready_timeout"}, 0, 1);
      return;
    end
    e.name = nm; e.key = ek; e.val = ev; e.cnt = ec; e.drop = ed;
    sb_q.push_back(e);
    wrt = w; rd = r; key = KW'(k); val = VW'(v);
    @(posedge clk); #1;
    if (hold) begin
      key = KW'(16'hFFFF); val = VW'(8'hEE);
      @(posedge clk); #1;
    end
    wrt = 1'b0; rd = 1'b0;
  endtask

  task automatic do_reset(input string nm, input int cycles);
    exp_t e;
    sb_q.delete();
    e.name = nm; e.key = 0; e.val = 0; e.cnt = 0; e.drop = 0;
    sb_q.push_back(e);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((acc_cnt != done_cnt || sb_q.size() != 0) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (acc_cnt != done_cnt || sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
  endtask

  // Reference model: an unordered array; the best entry is found by search.
  int mk [QS];
  int mv [QS];
  int mcnt;

  function automatic int mbest();
    int b;
    b = 0;
    for (int i = 1; i < mcnt; i++) if (mk[i] > mk[b]) b = i;
    return b;
  endfunction

  initial begin
    wrt = 1'b0; rd = 1'b0; key = '0; val = '0; sel = 1'b0;
    mcnt = 0;
    do_reset("reset0", 2);

    // Ties: the first 9 entered stays at the root. The last insert holds
    // the request through a busy edge.
    issue("t1_enq5", 1, 0, 5, 0, 5, 0, 1, 0, 0);
    issue("t1_enq9", 1, 0, 9, 1, 9, 1, 2, 0, 0);
    issue("t1_enq3", 1, 0, 3, 2, 9, 1, 3, 0, 0);
    issue("t1_enq9b", 1, 0, 9, 3, 9, 1, 4, 0, 1);
    drain();

    do_reset("reset1", 1);
    for (int i = 1; i <= 7; i++)
      issue($sformatf("t2_fill%0d", i), 1, 0, i * 100, i, i * 100, i, i, 0, 0);
    issue("t2_enq_full", 1, 0, 800, 8, 700, 7, 7, 1, 0);
    for (int i = 6; i >= 0; i--)
      issue($sformatf("t3_deq_to%0d", i), 0, 1, 0, 0, i * 100, i, i, 0, 0);
    issue("t3_deq_empty", 0, 1, 0, 0, 0, 0, 0, 1, 0);
    drain();

    do_reset("reset2", 1);
    issue("t4_enq50", 1, 0, 50, 1, 50, 1, 1, 0, 0);
    issue("t4_enq40", 1, 0, 40, 2, 50, 1, 2, 0, 0);
    issue("t4_enq30", 1, 0, 30, 3, 50, 1, 3, 0, 0);
    issue("t4_repl10", 1, 1, 10, 9, 40, 2, 3, 0, 0);
    issue("t4_deq_a", 0, 1, 0, 0, 30, 3, 2, 0, 0);
    issue("t4_deq_b", 0, 1, 0, 0, 10, 9, 1, 0, 0);
    issue("t4_deq_c", 0, 1, 0, 0, 0, 0, 0, 0, 0);
    issue("t4_repl_empty", 1, 1, 7, 5, 7, 5, 1, 0, 0);
    drain();

    sel = 1'b1;
    do_reset("reset_min", 1);
    issue("t5_min_enq5", 1, 0, 5, 1, 5, 1, 1, 0, 0);
    issue("t5_min_enq9", 1, 0, 9, 2, 5, 1, 2, 0, 0);
    issue("t5_min_enq3", 1, 0, 3, 3, 3, 3, 3, 0, 0);
    issue("t5_min_deq", 0, 1, 0, 0, 5, 1, 2, 0, 0);
    drain();

    sel = 1'b0;
    do_reset("reset3", 1);
    for (int i = 1; i <= 7; i++)
      issue($sformatf("t6_fill%0d", i), 1, 0, i * 10, i, i * 10, i, i, 0, 0);
    drain();
    // The dequeue starts a SIFT_DOWN. Reset is asserted on its first busy
    // edge, and the dequeue expectation is discarded.
    issue("t6_deq_aborted", 0, 1, 0, 0, 60, 6, 6, 0, 0);
    do_reset("t6_reset_mid_sift", 1);
    drain();

    mcnt = 0;
    for (int i = 0; i < 1000; i++) begin
      int r, op, k, v, b, ek, ev, ed, tries;
      bit dup;
      r = $urandom_range(0, 99);
      if ((i / 100) % 2 == 0) op = (r < 60) ? 0 : ((r < 85) ? 1 : 2);
      else                    op = (r < 25) ? 0 : ((r < 85) ? 1 : 2);
      tries = 0;
      do begin
        k = $urandom_range(0, 65535);
        dup = 1'b0;
        for (int j = 0; j < mcnt; j++) if (mk[j] == k) dup = 1'b1;
        tries++;
      end while (dup && tries < 50);
      v = $urandom_range(0, 255);
      ed = 0;
      if (op == 0 || (op == 2 && mcnt == 0)) begin
        if (mcnt == QS) ed = 1;
        else begin
          mk[mcnt] = k; mv[mcnt] = v; mcnt++;
        end
      end else if (op == 1) begin
        if (mcnt == 0) ed = 1;
        else begin
          b = mbest();
          mk[b] = mk[mcnt - 1]; mv[b] = mv[mcnt - 1]; mcnt--;
        end
      end else begin
        b = mbest();
        mk[b] = k; mv[b] = v;
      end
      if (mcnt == 0) begin
        ek = 0; ev = 0;
      end else begin
        b = mbest(); ek = mk[b]; ev = mv[b];
      end
      issue($sformatf("rnd%0d_op%0d", i, op), op != 1, op != 0, k, v, ek, ev, mcnt, ed, 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
